// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer: FSM states, branch
// condition codes and the per-program entry addresses.
package prog_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  typedef enum logic [1:0] {COND_ALWAYS, COND_FLAG, COND_NFLAG, COND_NEVER} cond_e;

  localparam int NUM_PROGS = 3;
  localparam logic [9:0] START_ADDR [0:NUM_PROGS-1] = '{10'd0, 10'd256, 10'd512};

  // Constant-index lookup; out-of-range program numbers map to address 0.
  function automatic logic [9:0] start_addr(input int idx);
    logic [9:0] a;
    a = '0;
    for (int i = 0; i < NUM_PROGS; i++)
      if (idx == i) a = START_ADDR[i];
    return a;
  endfunction

endpackage

// File: rtl/prog_seq_nextpc.sv
// Combinational next-PC select for the RUN state: halt holds, a taken branch
// loads the absolute target, otherwise the PC increments modulo 2^L.
module prog_seq_nextpc
  import prog_seq_pkg::*;
#(
  parameter int L = 10
) (
  input  logic [L-1:0] pc,
  input  logic         halt,
  input  logic         branch_en,
  input  cond_e        cond,
  input  logic         flag,
  input  logic [L-1:0] target,
  output logic [L-1:0] next_pc
);

  logic take;

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_ALWAYS: take = 1'b1;
      COND_FLAG:   take = flag;
      COND_NFLAG:  take = ~flag;
      default:     take = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc + L'(1);
    if (halt)                   next_pc = pc;
    else if (branch_en && take) next_pc = target;
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program-counter sequencer: Start-edge launch, one-cycle entry load, stepping
// with conditional branches, halt to DONE. Optional CycleCount via CYCLE_COUNT_EN.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int L      = 10,
  parameter int P_BITS = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [P_BITS-1:0] ProgSel,
  input  logic              BranchEn,
  input  logic [1:0]        BranchCond,
  input  logic              ALU_flag,
  input  logic [L-1:0]      Target,
  input  logic              HaltReq,
  output logic [L-1:0]      ProgCtr,
  output logic              Running,
  output logic              Done
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]       CycleCount
`endif
);

  state_e            state;
  logic              start_q;
  logic [P_BITS-1:0] sel_q;
  logic              start_rise;
  logic              launch;
  logic [L-1:0]      pc_next;

  assign start_rise = Start & ~start_q;
  assign launch     = start_rise && (int'(ProgSel) < NUM_PROGS);

  prog_seq_nextpc #(.L(L)) u_nextpc (
    .pc        (ProgCtr),
    .halt      (HaltReq),
    .branch_en (BranchEn),
    .cond      (cond_e'(BranchCond)),
    .flag      (ALU_flag),
    .target    (Target),
    .next_pc   (pc_next)
  );

  // Running/Done decode the state of the previous cycle, so they trail the
  // state register by one edge and can never be high together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      sel_q   <= '0;
      ProgCtr <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      start_q <= Start;
      Running <= (state == RUN);
      Done    <= (state == DONE);
      case (state)
        IDLE, DONE: if (launch) begin
          sel_q <= ProgSel;
          state <= LOAD;
        end
        LOAD: begin
          ProgCtr <= L'(start_addr(int'(sel_q)));
          state   <= RUN;
        end
        RUN: begin
          ProgCtr <= pc_next;
          if (HaltReq) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CYCLE_COUNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      CycleCount <= '0;
    else if (state == LOAD)
      CycleCount <= '0;
    else if (state == RUN && CycleCount != 16'hFFFF)
      CycleCount <= CycleCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus a randomized
// run against a cycle-level behavioural model.
module tb_prog_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] ProgSel;
  logic       BranchEn;
  logic [1:0] BranchCond;
  logic       ALU_flag;
  logic [9:0] Target;
  logic       HaltReq;
  logic [9:0] ProgCtr;
  logic       Running;
  logic       Done;
`ifdef CYCLE_COUNT_EN
  logic [15:0] CycleCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: st 0=idle 1=load 2=run 3=done
  int m_st = 0, m_pc = 0, m_sel = 0, m_cnt = 0;
  bit m_sq = 0, m_run = 0, m_done = 0;
  localparam int BASE [3] = '{0, 256, 512};

  prog_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ProgSel    (ProgSel),
    .BranchEn   (BranchEn),
    .BranchCond (BranchCond),
    .ALU_flag   (ALU_flag),
    .Target     (Target),
    .HaltReq    (HaltReq),
    .ProgCtr    (ProgCtr),
    .Running    (Running),
    .Done       (Done)
`ifdef CYCLE_COUNT_EN
    ,
    .CycleCount (CycleCount)
`endif
  );

  always #5 Clk = ~Clk;

  // Advance one clock; model computes the cycle's outcome from current inputs.
  task automatic tick();
    int st, pc, sel, cnt;
    bit sq, run, done, take;
    st = m_st; pc = m_pc; sel = m_sel; cnt = m_cnt;
    run = (m_st == 2); done = (m_st == 3); sq = Start;
    if (Reset) begin
      st = 0; pc = 0; sel = 0; cnt = 0; sq = 0; run = 0; done = 0;
    end else begin
      take = (BranchCond == 2'd0) || (BranchCond == 2'd1 && ALU_flag) ||
             (BranchCond == 2'd2 && !ALU_flag);
      case (m_st)
        0, 3: if (Start && !m_sq && ProgSel < 2'd3) begin sel = int'(ProgSel); st = 1; end
        1: begin pc = BASE[sel]; cnt = 0; st = 2; end
        2: begin
          if (cnt < 65535) cnt = cnt + 1;
          if (HaltReq) st = 3;
          else if (BranchEn && take) pc = int'(Target);
          else pc = (m_pc + 1) % 1024;
        end
        default: ;
      endcase
    end
    @(posedge Clk);
    #1;
    m_st = st; m_pc = pc; m_sel = sel; m_cnt = cnt; m_sq = sq; m_run = run; m_done = done;
  endtask

  task automatic quiet();
    BranchEn = 0; BranchCond = 2'd0; ALU_flag = 0; Target = '0; HaltReq = 0;
  endtask

  task automatic test_reset();
    Reset = 1; Start = 0; ProgSel = 0; quiet();
    tick(); tick();
    Reset = 0;
    tick();
    n_tests++; if (ProgCtr !== 10'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", ProgCtr); end
    n_tests++; if (Running !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%b exp=0", Running); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", Done); end
  endtask

  task automatic test_launch();
    Start = 1; ProgSel = 2'd1;
    tick();
    Start = 0;
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b0) begin n_fail++; $display("FAIL launch_edge pc=%0d run=%b exp pc=0 run=0", ProgCtr, Running); end
    tick();
    n_tests++; if (ProgCtr !== 10'd256 || Running !== 1'b0) begin n_fail++; $display("FAIL launch_load pc=%0d run=%b exp pc=256 run=0", ProgCtr, Running); end
    tick();
    n_tests++; if (ProgCtr !== 10'd257 || Running !== 1'b1) begin n_fail++; $display("FAIL launch_run1 pc=%0d run=%b exp pc=257 run=1", ProgCtr, Running); end
    tick();
    n_tests++; if (ProgCtr !== 10'd258 || Running !== 1'b1) begin n_fail++; $display("FAIL launch_run2 pc=%0d run=%b exp pc=258 run=1", ProgCtr, Running); end
  endtask

  task automatic test_branch();
    logic [1:0] conds [4] = '{2'd1, 2'd1, 2'd3, 2'd2};
    logic       flags [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         exps  [4] = '{100, 21, 21, 100};
    for (int k = 0; k < 4; k++) begin
      BranchEn = 1; BranchCond = 2'd0; Target = 10'd20;
      tick();
      BranchCond = conds[k]; ALU_flag = flags[k]; Target = 10'd100;
      tick();
      n_tests++;
      if (ProgCtr !== 10'(exps[k])) begin
        n_fail++; $display("FAIL branch_%0d cond=%0d flag=%b got=%0d exp=%0d", k, conds[k], flags[k], ProgCtr, exps[k]);
      end
    end
    quiet();
  endtask

  task automatic test_halt();
    // Start rises during RUN: must be ignored.
    Start = 1; ProgSel = 2'd2;
    BranchEn = 1; BranchCond = 2'd0; Target = 10'd40;
    tick();
    n_tests++; if (ProgCtr !== 10'd40 || Running !== 1'b1) begin n_fail++; $display("FAIL halt_setup pc=%0d run=%b exp pc=40 run=1", ProgCtr, Running); end
    HaltReq = 1; Target = 10'd100;
    tick();
    n_tests++; if (ProgCtr !== 10'd40) begin n_fail++; $display("FAIL halt_hold pc=%0d exp=40", ProgCtr); end
    quiet();
    tick();
    n_tests++; if (ProgCtr !== 10'd40 || Done !== 1'b1 || Running !== 1'b0) begin
      n_fail++; $display("FAIL halt_done pc=%0d done=%b run=%b exp pc=40 done=1 run=0", ProgCtr, Done, Running);
    end
  endtask

  task automatic test_relaunch();
    repeat (3) tick();
    n_tests++; if (ProgCtr !== 10'd40 || Done !== 1'b1) begin n_fail++; $display("FAIL held_start pc=%0d done=%b exp pc=40 done=1", ProgCtr, Done); end
    Start = 0;
    tick();
    Start = 1; ProgSel = 2'd2;
    tick();
    Start = 0;
    tick();
    n_tests++; if (ProgCtr !== 10'd512) begin n_fail++; $display("FAIL relaunch_pc got=%0d exp=512", ProgCtr); end
    tick();
    n_tests++; if (Running !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL relaunch_run run=%b done=%b exp run=1 done=0", Running, Done); end
  endtask

  task automatic test_invalid_and_reset();
    Reset = 1; tick(); Reset = 0;
    Start = 1; ProgSel = 2'd3;
    tick();
    Start = 0;
    tick(); tick();
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL sel3_ignored pc=%0d run=%b done=%b exp 0/0/0", ProgCtr, Running, Done);
    end
    Start = 1; ProgSel = 2'd1;
    tick();
    Start = 0;
    tick();
    BranchEn = 1; BranchCond = 2'd0; Target = 10'd300;
    tick();
    quiet();
    n_tests++; if (ProgCtr !== 10'd300 || Running !== 1'b1) begin n_fail++; $display("FAIL midrun_setup pc=%0d run=%b exp pc=300 run=1", ProgCtr, Running); end
    #2 Reset = 1;
    #1;
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset pc=%0d run=%b done=%b exp 0/0/0", ProgCtr, Running, Done);
    end
    tick();
    Reset = 0;
    tick(); tick();
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle pc=%0d run=%b done=%b exp 0/0/0", ProgCtr, Running, Done);
    end
  endtask

  task automatic test_wrap();
    Start = 1; ProgSel = 2'd0;
    tick();
    Start = 0;
    tick();
    n_tests++; if (ProgCtr !== 10'd0) begin n_fail++; $display("FAIL prog0_entry got=%0d exp=0", ProgCtr); end
    BranchEn = 1; BranchCond = 2'd0; Target = 10'd1023;
    tick();
    quiet();
    n_tests++; if (ProgCtr !== 10'd1023) begin n_fail++; $display("FAIL wrap_setup got=%0d exp=1023", ProgCtr); end
    tick();
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b1) begin n_fail++; $display("FAIL wrap pc=%0d run=%b exp pc=0 run=1", ProgCtr, Running); end
    HaltReq = 1; tick(); quiet(); tick();
  endtask

`ifdef CYCLE_COUNT_EN
  task automatic test_cycle_count();
    Reset = 1; tick(); Reset = 0;
    Start = 1; ProgSel = 2'd0;
    tick();
    Start = 0;
    tick();
    n_tests++; if (CycleCount !== 16'd0) begin n_fail++; $display("FAIL cc_load got=%0d exp=0", CycleCount); end
    repeat (4) tick();
    HaltReq = 1;
    tick();
    quiet();
    n_tests++; if (CycleCount !== 16'd5) begin n_fail++; $display("FAIL cc_halt got=%0d exp=5", CycleCount); end
    repeat (3) tick();
    n_tests++; if (CycleCount !== 16'd5 || Done !== 1'b1) begin n_fail++; $display("FAIL cc_frozen cnt=%0d done=%b exp cnt=5 done=1", CycleCount, Done); end
  endtask
`endif

  task automatic test_random();
    Reset = 1; Start = 0; quiet(); tick(); Reset = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) Start = ~Start;
      Reset      = ($urandom_range(0, 599) == 0);
      ProgSel    = 2'($urandom_range(0, 3));
      BranchEn   = 1'($urandom_range(0, 1));
      BranchCond = 2'($urandom_range(0, 3));
      ALU_flag   = 1'($urandom_range(0, 1));
      Target     = 10'($urandom);
      HaltReq    = ($urandom_range(0, 24) == 0);
      tick();
      n_tests++; if (ProgCtr !== 10'(m_pc)) begin n_fail++; $display("FAIL rand_pc cyc=%0d got=%0d exp=%0d", i, ProgCtr, m_pc); end
      n_tests++; if (Running !== m_run || Done !== m_done) begin
        n_fail++; $display("FAIL rand_flags cyc=%0d run=%b done=%b exp run=%b done=%b", i, Running, Done, m_run, m_done);
      end
`ifdef CYCLE_COUNT_EN
      n_tests++; if (CycleCount !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, CycleCount, m_cnt); end
`endif
    end
    Reset = 0;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_branch();
    test_halt();
    test_relaunch();
    test_invalid_and_reset();
    test_wrap();
`ifdef CYCLE_COUNT_EN
    test_cycle_count();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
